// File: rtl/int2fp_iter.sv
// Iterative integer-to-IEEE-754 converter (W=32 -> single, W=64 -> double).
// Normalizes by byte or bit shifts, one per cycle, then rounds to nearest-even.
module int2fp_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         is_signed,
  input  logic [W-1:0] in,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] out
);

  localparam int FW   = (W == 64) ? 52 : 23;
  localparam int EW   = (W == 64) ? 11 : 8;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam logic [EW-1:0] EXP_INIT = EW'(BIAS + W - 1);

  // Handshake: a request is taken on a rising edge where start=1 and ready=1;
  // start in any other cycle is dropped. valid is high for exactly one cycle
  // (state DONE) and out holds its value until the next result or reset.
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t         state, state_n;
  logic           sign, sign_n;
  logic [W-1:0]   mag, mag_n;
  logic [EW-1:0]  expo, expo_n;
  logic [W-1:0]   out_n;

  logic           in_neg;
  logic [W-1:0]   in_mag;
  logic [FW-1:0]  mant;
  logic           guard, sticky, round_up;
  logic [FW:0]    mant_inc;
  logic [FW-1:0]  mant_rnd;
  logic [EW-1:0]  expo_rnd;

  // Two's-complement negate of the signed minimum wraps to 2^(W-1), which is
  // exactly the magnitude wanted when read as unsigned.
  assign in_neg = is_signed & in[W-1];
  assign in_mag = in_neg ? (~in + 1'b1) : in;

  assign mant     = mag[W-2 -: FW];
  assign guard    = mag[W-2-FW];
  assign sticky   = |mag[W-3-FW:0];
  assign round_up = guard & (sticky | mant[0]);
  assign mant_inc = {1'b0, mant} + 1'b1;

  always_comb begin
    mant_rnd = mant;
    expo_rnd = expo;
    if (round_up) begin
      mant_rnd = mant_inc[FW-1:0];
      if (mant_inc[FW]) expo_rnd = expo + 1'b1;
    end
  end

  assign ready = (state == IDLE);
  assign valid = (state == DONE);

  always_comb begin
    state_n = state;
    sign_n  = sign;
    mag_n   = mag;
    expo_n  = expo;
    out_n   = out;
    case (state)
      IDLE: begin
        if (start) begin
          sign_n = in_neg;
          mag_n  = in_mag;
          expo_n = EXP_INIT;
          if (in_mag == '0) begin
            out_n   = '0;
            state_n = DONE;
          end else begin
            state_n = NORM;
          end
        end
      end
      NORM: begin
        if (mag[W-1]) begin
          state_n = ROUND;
        end else if (mag[W-1:W-8] == 8'h00) begin
          mag_n  = mag << 8;
          expo_n = expo - EW'(8);
        end else begin
          mag_n  = mag << 1;
          expo_n = expo - EW'(1);
        end
      end
      ROUND: begin
        out_n   = {sign, expo_rnd, mant_rnd};
        state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sign  <= 1'b0;
      mag   <= '0;
      expo  <= '0;
      out   <= '0;
    end else begin
      state <= state_n;
      sign  <= sign_n;
      mag   <= mag_n;
      expo  <= expo_n;
      out   <= out_n;
    end
  end

endmodule

// File: tb/tb_int2fp_iter.sv
// Bench for int2fp_iter: W=32 and W=64 instances, directed vector table,
// reset/back-to-back corner sequences, and random operands vs. an arithmetic model.
module tb_int2fp_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, sg32, ready32, valid32;
  logic [31:0] in32, out32;
  logic        start64, sg64, ready64, valid64;
  logic [63:0] in64, out64;

  int n_cmp = 0;
  int n_err = 0;

  int2fp_iter #(.W(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .is_signed(sg32), .in(in32),
    .ready(ready32), .valid(valid32), .out(out32)
  );

  int2fp_iter #(.W(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .is_signed(sg64), .in(in64),
    .ready(ready64), .valid(valid64), .out(out64)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wide;
    logic        sg;
    logic [63:0] v;
    logic [63:0] exp_out;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference: find the MSB position, scale the magnitude to FW+1 bits and
  // round the discarded remainder against one half.
  function automatic logic [63:0] ref_fp(input bit wide, input logic sg, input logic [63:0] v);
    int          w, fw, bias, p, sh, e;
    logic [63:0] mask, m, q, rem, half;
    logic        neg;
    w    = wide ? 64 : 32;
    fw   = wide ? 52 : 23;
    bias = wide ? 1023 : 127;
    mask = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    neg  = sg && v[w-1];
    m    = neg ? ((~v + 64'd1) & mask) : (v & mask);
    if (m == 64'd0) return 64'd0;
    p = 63;
    while (!m[p]) p--;
    e = bias + p;
    if (p <= fw) begin
      q = m << (fw - p);
    end else begin
      sh   = p - fw;
      q    = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q[fw+1]) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return (64'(neg) << (w - 1)) | (64'(e) << fw) | (q & ((64'd1 << fw) - 64'd1));
  endfunction

  function automatic int ref_lat(input bit wide, input logic sg, input logic [63:0] v);
    int          w, p, lz;
    logic [63:0] mask, m;
    w    = wide ? 64 : 32;
    mask = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    m    = (sg && v[w-1]) ? ((~v + 64'd1) & mask) : (v & mask);
    if (m == 64'd0) return 1;
    p = 63;
    while (!m[p]) p--;
    lz = w - 1 - p;
    return lz / 8 + lz % 8 + 3;
  endfunction

  // Called at a falling edge. lat counts rising edges from the accepting
  // edge (inclusive) to the first cycle showing valid; -1 on timeout.
  task automatic run_conv(input bit wide, input logic sg, input logic [63:0] v,
                          output logic [63:0] got, output int lat,
                          output bit rdy_ok, output bit pulse_ok);
    int guard_cnt;
    guard_cnt = 0;
    while (!(wide ? ready64 : ready32) && guard_cnt < 100) begin
      @(negedge clk);
      guard_cnt++;
    end
    if (wide) begin
      start64 = 1'b1; sg64 = sg; in64 = v;
    end else begin
      start32 = 1'b1; sg32 = sg; in32 = v[31:0];
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start32 = 1'b0;
    start64 = 1'b0;
    rdy_ok = 1'b1;
    while (!(wide ? valid64 : valid32) && lat < 200) begin
      if (wide ? ready64 : ready32) rdy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (wide ? ready64 : ready32) rdy_ok = 1'b0;
    got = 64'd0;
    pulse_ok = 1'b0;
    if (wide ? valid64 : valid32) begin
      got = wide ? out64 : {32'd0, out32};
      @(posedge clk);
      @(negedge clk);
      pulse_ok = wide ? (!valid64 && out64 == got) : (!valid32 && {32'd0, out32} == got);
    end else begin
      lat = -1;
    end
  endtask

  initial begin
    logic [63:0] got, v;
    int          lat;
    bit          rdy_ok, pulse_ok, saw_valid, wide;
    logic        sg;

    reset = 1'b1;
    start32 = 1'b0; sg32 = 1'b0; in32 = '0;
    start64 = 1'b0; sg64 = 1'b0; in64 = '0;

    vecs.push_back('{0, 1'b0, 64'h0000_0001,           64'h3F80_0000,           13});
    vecs.push_back('{0, 1'b1, 64'hFFFF_FFFF,           64'hBF80_0000,           13});
    vecs.push_back('{0, 1'b1, 64'h8000_0000,           64'hCF00_0000,           3});
    vecs.push_back('{0, 1'b1, 64'h7FFF_FFFF,           64'h4F00_0000,           4});
    vecs.push_back('{0, 1'b0, 64'hFFFF_FFFF,           64'h4F80_0000,           3});
    vecs.push_back('{0, 1'b0, 64'h0100_0001,           64'h4B80_0000,           10});
    vecs.push_back('{0, 1'b0, 64'h0100_0003,           64'h4B80_0002,           10});
    vecs.push_back('{0, 1'b0, 64'h0000_0000,           64'h0000_0000,           1});
    vecs.push_back('{0, 1'b1, 64'h0000_0000,           64'h0000_0000,           1});
    vecs.push_back('{0, 1'b0, 64'h0000_0005,           64'h40A0_0000,           11});
    vecs.push_back('{1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hBFF0_0000_0000_0000, 17});
    vecs.push_back('{1, 1'b0, 64'h0020_0000_0000_0001, 64'h4340_0000_0000_0000, 6});
    vecs.push_back('{1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h43F0_0000_0000_0000, 3});

    repeat (2) @(negedge clk);
    check("reset_ready32", 64'(ready32), 64'd1);
    check("reset_valid32", 64'(valid32), 64'd0);
    check("reset_out32",   64'(out32),   64'd0);
    check("reset_ready64", 64'(ready64), 64'd1);
    check("reset_valid64", 64'(valid64), 64'd0);
    check("reset_out64",   out64,        64'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_conv(vecs[i].wide, vecs[i].sg, vecs[i].v, got, lat, rdy_ok, pulse_ok);
      check($sformatf("vec%0d_out", i), got, vecs[i].exp_out);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d_ready_low", i), 64'(rdy_ok), 64'd1);
      check($sformatf("vec%0d_one_pulse", i), 64'(pulse_ok), 64'd1);
    end

    // start held high on a zero operand: re-accepted only when back in IDLE
    start32 = 1'b1; sg32 = 1'b0; in32 = 32'd0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("held_valid_%0d", k), 64'(valid32), 64'(k % 2));
    end
    start32 = 1'b0;
    check("held_out", 64'(out32), 64'd0);
    @(negedge clk);

    // reset in the middle of normalizing in=1
    start32 = 1'b1; sg32 = 1'b0; in32 = 32'd1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_ready", 64'(ready32), 64'd1);
    check("midreset_valid", 64'(valid32), 64'd0);
    check("midreset_out",   64'(out32),   64'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (valid32) saw_valid = 1'b1;
    end
    check("midreset_no_valid", 64'(saw_valid), 64'd0);
    run_conv(0, 1'b0, 64'd5, got, lat, rdy_ok, pulse_ok);
    check("after_reset_out", got, 64'h40A0_0000);
    check("after_reset_lat", 64'(lat), 64'd11);

    // random operands with varied leading-zero counts
    for (int k = 0; k < 300; k++) begin
      wide = (k % 3 == 2);
      sg   = 1'($urandom_range(0, 1));
      if (wide) v = {$urandom, $urandom} >> $urandom_range(0, 63);
      else      v = {32'd0, $urandom >> $urandom_range(0, 31)};
      run_conv(wide, sg, v, got, lat, rdy_ok, pulse_ok);
      check($sformatf("rnd%0d_out(w%0d s%0d in=%h)", k, wide ? 64 : 32, sg, v), got, ref_fp(wide, sg, v));
      check($sformatf("rnd%0d_lat", k), 64'(lat), 64'(ref_lat(wide, sg, v)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/int2fp_iter.md
Name: int2fp_iter

Overview:
- Multi-cycle integer-to-IEEE-754 converter; the inverse of the team's float-to-integer truncation unit.
- Accepts a W-bit signed or unsigned integer and produces a W-bit float of the same width, rounded to nearest-even.
- Normalizes iteratively (byte or bit shift per cycle) to keep area small.
- Sits in the FP execution path behind a start/ready/valid handshake.

Parameters:
W, 32, data/float width; legal values 32 (FW=23, EW=8) or 64 (FW=52, EW=11). FW and EW are local, derived from W; BIAS = 2^(EW-1)-1.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; accepted only in a cycle where ready=1
is_signed  input  1  1: treat in as two's complement; 0: unsigned
in  input  W  integer operand, sampled on the accepting edge
ready  output  1  high only in IDLE
valid  output  1  one-cycle pulse when out is new
out  output  W  float result; holds until the next result

Behaviour:
- States: IDLE, NORM, ROUND, DONE. ready = (state==IDLE).
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE, valid=0, out=0, internal registers cleared.
  - An in-flight conversion is discarded; no valid is produced for it.
- IDLE with start=1 (accepting edge):
  - sign = is_signed & in[W-1].
  - mag = sign ? -in : in, taken as a W-bit unsigned value. Signed minimum yields 2^(W-1) correctly.
  - exp = BIAS+W-1.
  - If mag==0, go to DONE with out=0 (+0.0, sign bit clear). Otherwise go to NORM.
- start while not ready: ignored, not queued.
- NORM, one step per cycle, priority order:
  - mag[W-1]=1: go to ROUND, no shift.
  - else mag[W-1:W-8]==0: mag <<= 8, exp -= 8.
  - else: mag <<= 1, exp -= 1.
- NORM cycle count N = floor(lz/8) + (lz mod 8) + 1, where lz = leading zeros of mag.
- ROUND (one cycle):
  - mant = mag[W-2:W-1-FW], guard = mag[W-2-FW], sticky = OR(mag[W-3-FW:0]).
  - Round up if guard & (sticky | mant[0]).
  - On mantissa carry-out: mant = 0, exp += 1.
  - Register out = {sign, exp[EW-1:0], mant}; go to DONE.
- DONE (one cycle): valid=1; next state IDLE.
- Latency, counted in edges from the accepting edge to the first cycle with valid=1:
  - Zero input: 1.
  - Non-zero input: N+2.
  - Minimum accept-to-accept spacing is latency+1.
- Exponent range: never overflows or underflows. Max is BIAS+W (159 for W=32, 1087 for W=64), which fits in EW bits. No NaN, Inf or denormal outputs are possible.
- out changes only on the ROUND or zero-capture update and on reset. It is stable while valid=0.

Test Plan:
- W=32, unsigned in=1 → out=0x3F800000; lz=31, N=11, valid 13 edges after accept; ready low throughout.
- W=32, signed in=0xFFFFFFFF → 0xBF800000. Signed in=0x80000000 → 0xCF000000, N=1, latency 3.
- W=32, rounding cases:
  - Signed 0x7FFFFFFF → 0x4F000000 (carry-out path).
  - Unsigned 0xFFFFFFFF → 0x4F800000.
  - Unsigned 0x01000001 → 0x4B800000 (tie, round to even).
  - Unsigned 0x01000003 → 0x4B800002 (tie, round up).
- W=32, in=0 (signed and unsigned) → out=0x00000000, valid 1 edge after accept. start held high in the following cycles is accepted only when ready=1.
- Assert reset during NORM of in=1 → valid never pulses, out=0, ready=1 immediately. A new conversion of unsigned 5 then gives 0x40A00000.
- W=64:
  - Signed -1 → 0xBFF0000000000000.
  - Unsigned 2^53+1 → 0x4340000000000000.
  - Unsigned 0xFFFFFFFFFFFFFFFF → 0x43F0000000000000.
